// File: rtl/data_cache_mp_pkg.sv
// data_cache_mp_pkg: shared defaults, FSM state encoding and helper for the multi-port data cache
// Contents:
//   DC_WORD_SIZE  default data/pointer width
//   dc_state_e    refill/write FSM states DC_IDLE, DC_WRITE, DC_REFILL
//   dc_popcount8  population count of up to eight hit flags
package data_cache_mp_pkg;

    localparam int DC_WORD_SIZE = 32;

    typedef enum logic [1:0] {
        DC_IDLE   = 2'd0,
        DC_WRITE  = 2'd1,
        DC_REFILL = 2'd2
    } dc_state_e;

    function automatic logic [3:0] dc_popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

endpackage

// File: rtl/data_cache_mp_dc_miss_arbiter.sv
// dc_miss_arbiter: combinational lowest-index priority picker over the read-miss vector
// Ports:
//   miss_i      per-port miss flags
//   grant_o     index of the lowest-numbered missing port (0 when none)
//   any_miss_o  at least one port is missing
module dc_miss_arbiter #(
    parameter int NUM_RD = 3,
    parameter int GW     = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
    input  logic [NUM_RD-1:0] miss_i,
    output logic [GW-1:0]     grant_o,
    output logic              any_miss_o
);

    // Scanning from the top down lets the lowest index overwrite last.
    always_comb begin
        grant_o = '0;
        for (int i = NUM_RD - 1; i >= 0; i--) begin
            if (miss_i[i]) grant_o = GW'(i);
        end
    end

    assign any_miss_o = |miss_i;

endmodule

// File: rtl/data_cache_mp.sv
// data_cache_mp: direct-mapped write-through multi-read-port data cache with one refill/write FSM
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   ptr_read, read_enable     NUM_RD packed read pointers and per-port requests
//   out, hit_read             per-port read data and combinational hit flags
//   ptr_write, val            write pointer and data
//   write_enable, hit_write   write request (held) and one-cycle completion pulse
//   mem_req/we/addr/wdata     backing memory request, held until mem_ack
//   mem_ack, mem_rdata        memory completion pulse and read data
//   stat_hits, stat_misses    saturating counters, present only with DCACHE_STATS_EN
// Build option: define DCACHE_STATS_EN to add the statistics counters.
module data_cache_mp
    import data_cache_mp_pkg::*;
#(
    parameter int WORD_SIZE  = DC_WORD_SIZE,
    parameter int NUM_RD     = 3,
    parameter int INDEX_BITS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_RD*WORD_SIZE-1:0] ptr_read,
    input  logic [NUM_RD-1:0]           read_enable,
    output logic [NUM_RD*WORD_SIZE-1:0] out,
    output logic [NUM_RD-1:0]           hit_read,
    input  logic [WORD_SIZE-1:0]        ptr_write,
    input  logic [WORD_SIZE-1:0]        val,
    input  logic                        write_enable,
    output logic                        hit_write,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [WORD_SIZE-1:0]        mem_addr,
    output logic [WORD_SIZE-1:0]        mem_wdata,
    input  logic                        mem_ack,
    input  logic [WORD_SIZE-1:0]        mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]                 stat_hits,
    output logic [31:0]                 stat_misses
`endif
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;
    localparam int GW       = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

    logic                  valid_q [LINES];
    logic [TAG_BITS-1:0]   tag_q   [LINES];
    logic [WORD_SIZE-1:0]  data_q  [LINES];

    dc_state_e             state_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic                  hit_write_q;
    logic [WORD_SIZE-1:0]  mem_addr_q;
    logic [WORD_SIZE-1:0]  mem_wdata_q;

    logic [WORD_SIZE-1:0]  rd_ptr [NUM_RD];
    logic [NUM_RD-1:0]     hit_raw;
    logic [NUM_RD-1:0]     miss;
    logic [GW-1:0]         grant;
    logic                  any_miss;

    logic [INDEX_BITS-1:0] wr_idx;
    logic [TAG_BITS-1:0]   wr_tag;

    always_comb begin
        out     = '0;
        hit_raw = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_ptr[i] = ptr_read[i*WORD_SIZE +: WORD_SIZE];
            out[i*WORD_SIZE +: WORD_SIZE] = data_q[rd_ptr[i][INDEX_BITS-1:0]];
            hit_raw[i] = valid_q[rd_ptr[i][INDEX_BITS-1:0]] &&
                         (tag_q[rd_ptr[i][INDEX_BITS-1:0]] == rd_ptr[i][WORD_SIZE-1:INDEX_BITS]);
        end
    end

    // Reset forces every port to report a miss, even in the reset cycle itself.
    assign hit_read = read_enable & hit_raw & {NUM_RD{~rst}};
    assign miss     = read_enable & ~hit_raw;

    dc_miss_arbiter #(
        .NUM_RD (NUM_RD),
        .GW     (GW)
    ) u_arb (
        .miss_i     (miss),
        .grant_o    (grant),
        .any_miss_o (any_miss)
    );

    // The captured memory address doubles as the line selector on completion.
    assign wr_idx = mem_addr_q[INDEX_BITS-1:0];
    assign wr_tag = mem_addr_q[WORD_SIZE-1:INDEX_BITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DC_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            hit_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int l = 0; l < LINES; l++) valid_q[l] <= 1'b0;
        end else begin
            hit_write_q <= 1'b0;
            case (state_q)
                DC_IDLE: begin
                    // write_enable is still high while hit_write is shown; do not restart it.
                    if (write_enable && !hit_write_q) begin
                        state_q     <= DC_WRITE;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= ptr_write;
                        mem_wdata_q <= val;
                    end else if (any_miss) begin
                        state_q    <= DC_REFILL;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= rd_ptr[grant];
                    end
                end
                DC_WRITE: begin
                    if (mem_ack) begin
                        if (valid_q[wr_idx] && tag_q[wr_idx] == wr_tag) data_q[wr_idx] <= mem_wdata_q;
                        hit_write_q <= 1'b1;
                        mem_req_q   <= 1'b0;
                        state_q     <= DC_IDLE;
                    end
                end
                DC_REFILL: begin
                    if (mem_ack) begin
                        valid_q[wr_idx] <= 1'b1;
                        tag_q[wr_idx]   <= wr_tag;
                        data_q[wr_idx]  <= mem_rdata;
                        mem_req_q       <= 1'b0;
                        state_q         <= DC_IDLE;
                    end
                end
                default: state_q <= DC_IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign hit_write = hit_write_q;

`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hits_q;
    logic [31:0] stat_misses_q;
    logic [32:0] hits_sum;

    assign hits_sum = {1'b0, stat_hits_q} + 33'(dc_popcount8(8'(hit_read)));

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else begin
            stat_hits_q <= hits_sum[32] ? '1 : hits_sum[31:0];
            if (state_q == DC_REFILL && mem_ack && stat_misses_q != '1) stat_misses_q <= stat_misses_q + 32'd1;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`endif

endmodule

// File: doc/data_cache_mp.md
Name: data_cache_mp

Overview:
- Parametrised multi-port data cache: NUM_RD read ports, one write port, direct-mapped, one word per line, word-addressed pointers.
- Write-through, no-write-allocate; on a write hit the cached line is updated.
- A single refill/write FSM serialises misses and writes to the backing data memory over a req/ack handshake.
- Sits between the CPU execute/memory stages and data memory, replacing the fixed 3-read-port cache.

Parameters:
WORD_SIZE, 32, data and pointer width in bits
NUM_RD, 3, number of read ports (1..8)
INDEX_BITS, 4, log2 of line count; tag = ptr[WORD_SIZE-1:INDEX_BITS]

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
ptr_read  in  NUM_RD*WORD_SIZE  read pointers; port i = bits [i*WORD_SIZE +: WORD_SIZE]
read_enable  in  NUM_RD  per-port read request
out  out  NUM_RD*WORD_SIZE  per-port read data, valid when matching hit_read bit is 1
hit_read  out  NUM_RD  per-port hit, combinational
ptr_write  in  WORD_SIZE  write pointer
val  in  WORD_SIZE  write data
write_enable  in  1  write request; held until hit_write
hit_write  out  1  one-cycle pulse: write completed
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write, 0 = read; stable while mem_req
mem_addr  out  WORD_SIZE  memory word address; stable while mem_req
mem_wdata  out  WORD_SIZE  memory write data
mem_ack  in  1  one-cycle completion pulse from memory
mem_rdata  in  WORD_SIZE  read data, valid with mem_ack

Behaviour:
- Storage: 2^INDEX_BITS entries of {valid, tag, data}. Reset clears all valid bits only.
- Read hit (combinational): hit_read[i] = read_enable[i] & valid[idx] & tag match; out[i] = data[idx]. With read_enable[i]=0: hit_read[i]=0, out[i] = don't-care (drive data[idx]).
- Read miss: read_enable[i]=1 and not hit. CPU holds request until hit.
- FSM states IDLE, WRITE, REFILL.
  - IDLE: write_enable=1 -> WRITE (writes take priority over refills). Else any read miss -> REFILL for the lowest-index missing port; capture its pointer.
  - WRITE: mem_req=1, mem_we=1, mem_addr=ptr_write, mem_wdata=val. On mem_ack: if the line tag matches and valid, update data; pulse hit_write; -> IDLE.
  - REFILL: mem_req=1, mem_we=0, mem_addr=captured pointer. On mem_ack: write {1, tag, mem_rdata} to the line (evicting); -> IDLE. The port hits the next cycle.
- Minimum latency:
  - Read miss: 3 cycles to hit with zero-wait memory (IDLE->REFILL, ack, hit).
  - Write: hit_write in the cycle after mem_ack.
- Simultaneous events:
  - Several ports missing: served one per refill, lowest index first. Ports sharing a pointer are satisfied by one refill.
  - Read of a line being written in the same cycle returns old cached data; it reflects the new value from the cycle after ack.
  - Refill eviction of a line another port hit earlier: that port sees a miss and re-requests.
- Reset in any state:
  - FSM -> IDLE, mem_req=0, hit_write=0, all hit_read=0.
  - A mem_ack arriving after reset while in IDLE is ignored.
- mem_ack outside WRITE/REFILL is ignored.

Optional Feature:
- Macro DCACHE_STATS_EN adds outputs stat_hits and stat_misses (32 bits each, saturating, cleared by rst).
  - stat_hits += popcount(hit_read) per cycle.
  - stat_misses += 1 per completed refill.
- Without the macro, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/include (parameters.v): WORD_SIZE, FSM state encodings DC_IDLE/DC_WRITE/DC_REFILL.
- Sub-module dc_miss_arbiter: a combinational lowest-index priority picker over the NUM_RD miss vector; outputs grant index and any_miss.

Test Plan:
- Reset, read ptr 3/13/23 on ports 0-2 -> all miss. Memory returns 3 refills in order addr 3, 13, 23; each port hits the cycle after its ack, out = mem_rdata.
- Ports 0 and 2 both read ptr 5 (miss) -> exactly one refill of addr 5; both hit together.
- Line 3 cached with 0xAA; write ptr 3 val 0x55 -> memory write addr 3. hit_write pulses one cycle after ack; port 0 reads 0xAA before ack and 0x55 after.
- Write ptr 7 (not cached) while port 1 misses ptr 9 -> write is issued first. Line 7 is not allocated: a read of 7 misses afterwards.
- ptr 4 and ptr 20 (same index, INDEX_BITS=4): refill 20 evicts 4 -> a subsequent read of 4 misses.
- rst asserted mid-REFILL (mem_req=1) -> mem_req=0 next cycle. A late mem_ack is ignored; the line stays invalid.
